modexp_sequencer: RTL and testbench
===================================

# modexp_sequencer

Master-side sequencer for modular exponentiation in the ElGamal datapath. Accepts one (base, exponent, modulus) job on an AXI-stream slave, computes base^exponent mod modulus by left-to-right square-and-multiply, and drives an external `multiplication_modulo` instance through its three operand streams and its result stream. It is the initiator of that AXI-stream protocol. It sits between the key/cipher control and the shared modular multiplier.

## Interface
- `SIZE`, 64: operand width in bits (base, exponent, modulus, result).
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `job_base_tdata`  in  SIZE: base.
- `job_exp_tdata`  in  SIZE: exponent.
- `job_mod_tdata`  in  SIZE: modulus; must be ≥ 2; 0 and 1 are undefined.
- `job_tvalid`  in  1: all three job fields valid.
- `job_tready`  out  1: high only in IDLE.
- `res_tdata`  out  SIZE: result.
- `res_tvalid`  out  1: result valid.
- `res_tready`  in  1: downstream accepts result.
- `mm_multiplier_tdata` / `mm_multiplicand_tdata` / `mm_modulus_tdata`  out  SIZE: operands to the multiplier.
- `mm_multiplier_tvalid` / `mm_multiplicand_tvalid` / `mm_modulus_tvalid`  out  1: per-channel valid.
- `mm_multiplier_tready` / `mm_multiplicand_tready` / `mm_modulus_tready`  in  1: per-channel ready.
- `mm_result_tdata`  in  SIZE: product mod modulus.
- `mm_result_tvalid`  in  1: result valid.
- `mm_result_tready`  out  1: high only in SQ_WAIT/MUL_WAIT.

## Operation
- Registers: `base_r`, `exp_r`, `mod_r`, `acc` (SIZE), `bit_idx` (clog2(SIZE)), `seen_one`, and three per-channel `sent` flags.
- IDLE: `job_tready`=1. On `job_tvalid`, latch all fields, `acc`←1, `bit_idx`←SIZE-1, `seen_one`←0, go to SCAN.
- SCAN (1 cycle per bit): b = `exp_r[bit_idx]`.
  - If `seen_one`=1, go to SQ_ISSUE.
  - Else if b=1, set `seen_one`, go to MUL_ISSUE. The leading square of 1 is skipped.
  - Else if `bit_idx`=0, go to DONE. In this case exponent=0 and the result is 1.
  - Else decrement `bit_idx` and stay in SCAN.
- SQ_ISSUE: drive operands (`acc`, `acc`, `mod_r`).
  - Each channel's tvalid is high until that channel's tready is sampled high; its `sent` flag is then set and its tvalid drops.
  - When all three `sent` flags are set, clear them and go to SQ_WAIT.
- SQ_WAIT: on `mm_result_tvalid`, set `acc`←`mm_result_tdata`. Go to MUL_ISSUE if b=1, else to NEXT.
- MUL_ISSUE / MUL_WAIT: same as the square path with operands (`acc`, `base_r`, `mod_r`). On result, `acc`←result, go to NEXT.
- NEXT: if `bit_idx`=0, go to DONE; else decrement and go to SCAN.
- DONE: `res_tvalid`=1, `res_tdata`=`acc`. On `res_tready`, go to IDLE.
- Arithmetic is performed entirely by the external multiplier. This block never multiplies or reduces. A base ≥ modulus is reduced by the first multiply.
- The operand tdata for a channel is stable while its tvalid is high.

## Timing
- Reset (`rst`=0): state=IDLE, all tvalid=0, `job_tready`=0 while in reset then 1, `mm_result_tready`=0, `res_tdata`=0, all registers=0.
- `job_tready` is registered from state: it is 1 in the first cycle after reset release.
- Job accept to first issue: 1 cycle plus leading-zero count, at 1 cycle per bit.
- Per set bit after the first: 2 multiplier round trips. Per clear bit: 1 round trip. Each round trip is issue (≥1 cycle) + multiplier latency + 1.
- Exponent 0: `res_tvalid` rises SIZE+1 cycles after job accept, with `res_tdata`=1.
- Channels can accept in different cycles. No channel is re-issued after its `sent` flag is set.
- `mm_result_tvalid` seen outside SQ_WAIT/MUL_WAIT is ignored; `mm_result_tready`=0 there.
- `res_tvalid`/`res_tdata` stay stable until `res_tready`. No new job is accepted until the result is taken.
- Reset mid-operation: returns to IDLE immediately and drops all tvalid. The bench must also reset the multiplier, since it has no flush.

## Structure
- Package `modexp_pkg`:
  - enum `modexp_state_t` {IDLE, SCAN, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, NEXT, DONE};
  - `MODEXP_BIT_IDX_W` = $clog2(SIZE).
- One natural sub-module: `axis_triple_issue`. It holds the three sent flags, generates per-channel tvalid, and outputs `all_sent`; it is used by both ISSUE states.
- The multiplier is not instantiated here. The top level connects `mm_*` to `multiplication_modulo`.

## Test plan
- base=4, exp=13, mod=497 → `res_tdata`=445; exactly 3 squares and 3 multiplies issued.
- base=2, exp=10, mod=1000 → 24.
- base=5, exp=0, mod=7 → 1; no `mm_*` tvalid ever asserted; latency SIZE+1.
- base=1000, exp=1, mod=7 (base ≥ mod) → 6; exactly one multiply, zero squares.
- Random per-channel tready stalls (0–5 cycles each) plus `res_tready` held low 10 cycles, with base=3, exp=200, mod=1009 → result matches the golden model. Check: no channel issued twice per op; `res_tdata` stable while stalled.
- `rst` pulsed low during MUL_WAIT → all outputs at reset values next edge; a following job base=2, exp=10, mod=1000 → 24.

Source files
------------

// File: rtl/modexp_pkg.sv
// rtl/modexp_pkg.sv - shared state encoding and widths for the modexp sequencer
package modexp_pkg;

  localparam int MODEXP_SIZE      = 64;
  localparam int MODEXP_BIT_IDX_W = $clog2(MODEXP_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SQ_ISSUE,
    SQ_WAIT,
    MUL_ISSUE,
    MUL_WAIT,
    NEXT,
    DONE
  } modexp_state_t;

endpackage

// File: rtl/modexp_sequencer_axis_triple_issue.sv
// rtl/modexp_sequencer_axis_triple_issue.sv - one-shot issue of three operand streams
module axis_triple_issue (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active_i,
  input  logic [2:0] tready_i,
  output logic [2:0] tvalid_o,
  output logic       all_sent_o
);

  logic [2:0] sent_q;
  logic [2:0] sent_d;
  logic [2:0] fire;

  // A channel offers its operand until accepted; the op completes once every channel is accepted.
  always_comb begin
    tvalid_o   = active_i ? ~sent_q : 3'b000;
    fire       = tvalid_o & tready_i;
    all_sent_o = active_i & (&(sent_q | fire));
    sent_d     = sent_q | fire;
    if (!active_i || all_sent_o) begin
      sent_d = 3'b000;
    end
  end

  // Per-channel sent flags, cleared when the op completes so the next issue starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_q <= 3'b000;
    end else begin
      sent_q <= sent_d;
    end
  end

endmodule

// File: rtl/modexp_sequencer.sv
// rtl/modexp_sequencer.sv - left-to-right square-and-multiply driver for an external modular multiplier
module modexp_sequencer
  import modexp_pkg::*;
#(
  parameter int SIZE = MODEXP_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] job_base_tdata,
  input  logic [SIZE-1:0] job_exp_tdata,
  input  logic [SIZE-1:0] job_mod_tdata,
  input  logic            job_tvalid,
  output logic            job_tready,
  output logic [SIZE-1:0] res_tdata,
  output logic            res_tvalid,
  input  logic            res_tready,
  output logic [SIZE-1:0] mm_multiplier_tdata,
  output logic [SIZE-1:0] mm_multiplicand_tdata,
  output logic [SIZE-1:0] mm_modulus_tdata,
  output logic            mm_multiplier_tvalid,
  output logic            mm_multiplicand_tvalid,
  output logic            mm_modulus_tvalid,
  input  logic            mm_multiplier_tready,
  input  logic            mm_multiplicand_tready,
  input  logic            mm_modulus_tready,
  input  logic [SIZE-1:0] mm_result_tdata,
  input  logic            mm_result_tvalid,
  output logic            mm_result_tready
);

  localparam int IW = $clog2(SIZE);

  modexp_state_t   state_q;
  logic [SIZE-1:0] base_q;
  logic [SIZE-1:0] exp_q;
  logic [SIZE-1:0] mod_q;
  logic [SIZE-1:0] acc_q;
  logic [IW-1:0]   bit_idx_q;
  logic            seen_one_q;
  logic            job_tready_q;

  logic            exp_bit;
  logic            issue_active;
  logic            all_sent;
  logic [2:0]      mm_tvalid;

  assign exp_bit      = exp_q[bit_idx_q];
  assign issue_active = (state_q == SQ_ISSUE) || (state_q == MUL_ISSUE);

  axis_triple_issue u_issue (
    .clk        (clk),
    .rst_n      (rst),
    .active_i   (issue_active),
    .tready_i   ({mm_modulus_tready, mm_multiplicand_tready, mm_multiplier_tready}),
    .tvalid_o   (mm_tvalid),
    .all_sent_o (all_sent)
  );

  assign mm_multiplier_tvalid   = mm_tvalid[0];
  assign mm_multiplicand_tvalid = mm_tvalid[1];
  assign mm_modulus_tvalid      = mm_tvalid[2];

  // Squares feed acc twice; multiplies pair acc with the latched base.
  assign mm_multiplier_tdata   = acc_q;
  assign mm_multiplicand_tdata = (state_q == MUL_ISSUE) ? base_q : acc_q;
  assign mm_modulus_tdata      = mod_q;

  assign mm_result_tready = (state_q == SQ_WAIT) || (state_q == MUL_WAIT);
  assign res_tvalid       = (state_q == DONE);
  assign res_tdata        = acc_q;
  assign job_tready       = job_tready_q;

  // Sequencer FSM: scan past leading zeros, then one square per bit plus a multiply per set bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      exp_q        <= '0;
      mod_q        <= '0;
      acc_q        <= '0;
      bit_idx_q    <= '0;
      seen_one_q   <= 1'b0;
      job_tready_q <= 1'b0;
    end else begin
      job_tready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (job_tvalid && job_tready_q) begin
            base_q     <= job_base_tdata;
            exp_q      <= job_exp_tdata;
            mod_q      <= job_mod_tdata;
            acc_q      <= SIZE'(1);
            bit_idx_q  <= IW'(SIZE - 1);
            seen_one_q <= 1'b0;
            state_q    <= SCAN;
          end else begin
            job_tready_q <= 1'b1;
          end
        end
        SCAN: begin
          if (seen_one_q) begin
            state_q <= SQ_ISSUE;
          end else if (exp_bit) begin
            // First set bit: squaring acc=1 is pointless, go straight to the multiply.
            seen_one_q <= 1'b1;
            state_q    <= MUL_ISSUE;
          end else if (bit_idx_q == '0) begin
            state_q <= DONE;
          end else begin
            bit_idx_q <= bit_idx_q - 1'b1;
          end
        end
        SQ_ISSUE: begin
          if (all_sent) state_q <= SQ_WAIT;
        end
        SQ_WAIT: begin
          if (mm_result_tvalid) begin
            acc_q   <= mm_result_tdata;
            state_q <= exp_bit ? MUL_ISSUE : NEXT;
          end
        end
        MUL_ISSUE: begin
          if (all_sent) state_q <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (mm_result_tvalid) begin
            acc_q   <= mm_result_tdata;
            state_q <= NEXT;
          end
        end
        NEXT: begin
          if (bit_idx_q == '0) begin
            state_q <= DONE;
          end else begin
            bit_idx_q <= bit_idx_q - 1'b1;
            state_q   <= SCAN;
          end
        end
        DONE: begin
          if (res_tready) begin
            state_q      <= IDLE;
            job_tready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_sequencer.sv
// tb/tb_modexp_sequencer.sv - scoreboard bench for modexp_sequencer with a behavioural multiplier
`timescale 1ns/1ps
module tb_modexp_sequencer;

  localparam int SIZE = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [SIZE-1:0] job_base_tdata, job_exp_tdata, job_mod_tdata;
  logic            job_tvalid, job_tready;
  logic [SIZE-1:0] res_tdata;
  logic            res_tvalid, res_tready;
  logic [SIZE-1:0] mm_multiplier_tdata, mm_multiplicand_tdata, mm_modulus_tdata;
  logic            mm_multiplier_tvalid, mm_multiplicand_tvalid, mm_modulus_tvalid;
  logic [2:0]      mm_tr;
  logic [SIZE-1:0] mm_result_tdata;
  logic            mm_result_tvalid, mm_result_tready;

  logic [2:0]      mm_tv;
  logic [SIZE-1:0] mm_td [3];
  assign mm_tv    = {mm_modulus_tvalid, mm_multiplicand_tvalid, mm_multiplier_tvalid};
  assign mm_td[0] = mm_multiplier_tdata;
  assign mm_td[1] = mm_multiplicand_tdata;
  assign mm_td[2] = mm_modulus_tdata;

  modexp_sequencer #(.SIZE(SIZE)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .job_base_tdata         (job_base_tdata),
    .job_exp_tdata          (job_exp_tdata),
    .job_mod_tdata          (job_mod_tdata),
    .job_tvalid             (job_tvalid),
    .job_tready             (job_tready),
    .res_tdata              (res_tdata),
    .res_tvalid             (res_tvalid),
    .res_tready             (res_tready),
    .mm_multiplier_tdata    (mm_multiplier_tdata),
    .mm_multiplicand_tdata  (mm_multiplicand_tdata),
    .mm_modulus_tdata       (mm_modulus_tdata),
    .mm_multiplier_tvalid   (mm_multiplier_tvalid),
    .mm_multiplicand_tvalid (mm_multiplicand_tvalid),
    .mm_modulus_tvalid      (mm_modulus_tvalid),
    .mm_multiplier_tready   (mm_tr[0]),
    .mm_multiplicand_tready (mm_tr[1]),
    .mm_modulus_tready      (mm_tr[2]),
    .mm_result_tdata        (mm_result_tdata),
    .mm_result_tvalid       (mm_result_tvalid),
    .mm_result_tready       (mm_result_tready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  longint cyc  = 0;
  int op_count = 0;
  int mm_valid_cycles = 0;
  int mm_latency = 2;
  bit check_ops  = 1'b0;
  bit rand_mode  = 1'b0;
  logic [SIZE-1:0] exp_m;
  logic [SIZE-1:0] exp_res_q [$];
  logic [SIZE-1:0] exp_a_q [$];
  logic [SIZE-1:0] exp_b_q [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (|mm_tv) mm_valid_cycles <= mm_valid_cycles + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [63:0] golden(input logic [63:0] b, input logic [63:0] e, input logic [63:0] m);
    logic [127:0] r, x;
    r = 128'd1;
    x = 128'(b) % 128'(m);
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * x) % 128'(m);
      x = (x * x) % 128'(m);
    end
    return r[63:0];
  endfunction

  task automatic push_op(input logic [63:0] a, input logic [63:0] b);
    exp_a_q.push_back(a);
    exp_b_q.push_back(b);
  endtask

  // Behavioural multiplier: per-channel accept with optional stalls, fixed latency, result hold.
  initial begin : mm_model
    logic [2:0]   got;
    logic [63:0]  cap [3];
    int           stall [3];
    bit           busy, dup, hs_res;
    int           lat;
    logic [127:0] prod;
    logic [63:0]  ea, eb;
    got = '0; busy = 1'b0; dup = 1'b0; lat = 0; prod = '0;
    for (int c = 0; c < 3; c++) begin stall[c] = 0; cap[c] = '0; end
    mm_tr = '0; mm_result_tvalid = 1'b0; mm_result_tdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        got = '0; busy = 1'b0; dup = 1'b0; lat = 0;
        mm_tr = '0; mm_result_tvalid = 1'b0; mm_result_tdata = '0;
        for (int c = 0; c < 3; c++) stall[c] = 0;
      end else begin
        hs_res = mm_result_tvalid && mm_result_tready;
        for (int c = 0; c < 3; c++) begin
          if (mm_tr[c] && mm_tv[c]) begin
            got[c] = 1'b1;
            cap[c] = mm_td[c];
          end else if (got[c] && mm_tv[c]) begin
            dup = 1'b1;
          end else if (mm_tv[c] && stall[c] > 0) begin
            stall[c]--;
          end
        end
        @(posedge clk); #1;
        if (rst) begin
          if (hs_res) begin
            check("no_reissue", 64'(dup), 64'd0);
            mm_result_tvalid = 1'b0;
            got = '0; busy = 1'b0; dup = 1'b0;
            op_count++;
            for (int c = 0; c < 3; c++) stall[c] = rand_mode ? int'($urandom_range(0, 5)) : 0;
          end else if (&got && !busy) begin
            busy = 1'b1;
            lat  = mm_latency;
            prod = (128'(cap[0]) * 128'(cap[1])) % 128'(cap[2]);
            if (check_ops) begin
              if (exp_a_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL op_extra: multiplier %0d multiplicand %0d issued, none expected", cap[0], cap[1]);
              end else begin
                ea = exp_a_q.pop_front();
                eb = exp_b_q.pop_front();
                check("op_multiplier", cap[0], ea);
                check("op_multiplicand", cap[1], eb);
                check("op_modulus", cap[2], exp_m);
              end
            end
          end else if (busy && !mm_result_tvalid) begin
            if (lat > 0) begin
              lat--;
            end else begin
              mm_result_tvalid = 1'b1;
              mm_result_tdata  = prod[63:0];
            end
          end
          for (int c = 0; c < 3; c++) mm_tr[c] = !got[c] && (stall[c] == 0);
        end
      end
    end
  end

  // Result monitor: pops the scoreboard on each result handshake and checks hold stability.
  initial begin : res_monitor
    logic [63:0] hold, e;
    bit hold_v, moved;
    hold = '0; hold_v = 1'b0; moved = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_v = 1'b0; moved = 1'b0;
      end else if (res_tvalid && res_tready) begin
        if (exp_res_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL res_unexpected: got %0d with no job pending", res_tdata);
        end else begin
          e = exp_res_q.pop_front();
          check("result", res_tdata, e);
        end
        if (hold_v) check("res_stable", 64'(moved), 64'd0);
        hold_v = 1'b0; moved = 1'b0;
      end else if (res_tvalid) begin
        if (hold_v && res_tdata !== hold) moved = 1'b1;
        hold = res_tdata;
        hold_v = 1'b1;
      end
    end
  end

  task automatic issue_job(input logic [63:0] b, input logic [63:0] e, input logic [63:0] m,
                           output bit ok, output longint t0);
    int t;
    t = 0; ok = 1'b1; t0 = 0;
    @(negedge clk);
    while (!job_tready && t < 200) begin @(negedge clk); t++; end
    if (!job_tready) begin
      n_checks++; n_fail++;
      $display("FAIL job_accept_timeout: job_tready 0 after %0d cycles, expected 1", t);
      ok = 1'b0;
      return;
    end
    @(posedge clk); #1;
    job_base_tdata = b; job_exp_tdata = e; job_mod_tdata = m; job_tvalid = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    job_tvalid = 1'b0;
  endtask

  task automatic run_job(input logic [63:0] b, input logic [63:0] e, input logic [63:0] m,
                         input logic [63:0] r, input int hold, output int lat);
    int t; bit ok; longint t0;
    lat = -1;
    exp_res_q.push_back(r);
    issue_job(b, e, m, ok, t0);
    if (!ok) begin exp_res_q.delete(); return; end
    t = 0;
    @(negedge clk);
    while (!res_tvalid && t < 5000) begin @(negedge clk); t++; end
    if (!res_tvalid) begin
      n_checks++; n_fail++;
      $display("FAIL res_timeout: res_tvalid 0 after %0d cycles, expected 1", t);
      exp_res_q.delete();
      return;
    end
    lat = int'(cyc - t0);
    repeat (hold) @(posedge clk);
    @(posedge clk); #1 res_tready = 1'b1;
    @(posedge clk); #1 res_tready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, {58'd0, job_tready, res_tvalid, mm_result_tready, mm_tv}, 64'd0);
    check({tag, "_res_tdata"}, res_tdata, 64'd0);
    check({tag, "_mm_tdata"}, mm_td[0] | mm_td[1] | mm_td[2], 64'd0);
  endtask

  initial begin : stimulus
    int lat, ops0, mv0, t;
    bit ok;
    longint t0;
    job_base_tdata = '0; job_exp_tdata = '0; job_mod_tdata = '0;
    job_tvalid = 1'b0; res_tready = 1'b0; exp_m = '0;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 check("job_tready_after_reset", 64'(job_tready), 64'd1);

    // 4^13 mod 497: leading multiply, then S, M, S, S, M
    check_ops = 1'b1; exp_m = 64'd497;
    push_op(1, 4); push_op(4, 4); push_op(16, 4); push_op(64, 64); push_op(120, 120); push_op(484, 4);
    ops0 = op_count;
    run_job(64'd4, 64'd13, 64'd497, 64'd445, 0, lat);
    check("t1_op_count", 64'(op_count - ops0), 64'd6);
    check("t1_ops_left", 64'(exp_a_q.size()), 64'd0);

    // 2^10 mod 1000
    exp_m = 64'd1000;
    push_op(1, 2); push_op(2, 2); push_op(4, 4); push_op(16, 2); push_op(32, 32);
    ops0 = op_count;
    run_job(64'd2, 64'd10, 64'd1000, 64'd24, 0, lat);
    check("t2_op_count", 64'(op_count - ops0), 64'd5);

    // exponent 0: no multiplier traffic, fixed latency
    ops0 = op_count; mv0 = mm_valid_cycles;
    run_job(64'd5, 64'd0, 64'd7, 64'd1, 0, lat);
    check("t3_latency", 64'(lat), 64'(SIZE + 1));
    check("t3_mm_valid_cycles", 64'(mm_valid_cycles - mv0), 64'd0);
    check("t3_op_count", 64'(op_count - ops0), 64'd0);

    // base >= modulus: single multiply reduces it
    exp_m = 64'd7;
    push_op(1, 1000);
    ops0 = op_count;
    run_job(64'd1000, 64'd1, 64'd7, 64'd6, 0, lat);
    check("t4_op_count", 64'(op_count - ops0), 64'd1);

    // random channel stalls and a stalled result
    check_ops = 1'b0; rand_mode = 1'b1;
    ops0 = op_count;
    run_job(64'd3, 64'd200, 64'd1009, golden(64'd3, 64'd200, 64'd1009), 10, lat);
    check("t5_op_count", 64'(op_count - ops0), 64'd10);
    rand_mode = 1'b0;

    // reset during MUL_WAIT, then a clean job
    mm_latency = 6;
    issue_job(64'd2, 64'd10, 64'd1000, ok, t0);
    if (ok) begin
      t = 0;
      @(negedge clk);
      while (!mm_result_tready && t < 500) begin @(negedge clk); t++; end
      check("t6_reached_wait", 64'(mm_result_tready), 64'd1);
      @(posedge clk); #2 rst = 1'b0;
      #1 check_reset_outputs("midrst_async");
      @(posedge clk); #1 check_reset_outputs("midrst_edge");
      @(posedge clk); #2 rst = 1'b1;
    end
    mm_latency = 2;
    check_ops = 1'b1; exp_m = 64'd1000;
    push_op(1, 2); push_op(2, 2); push_op(4, 4); push_op(16, 2); push_op(32, 32);
    ops0 = op_count;
    run_job(64'd2, 64'd10, 64'd1000, 64'd24, 0, lat);
    check("t6_op_count", 64'(op_count - ops0), 64'd5);
    check("res_queue_empty", 64'(exp_res_q.size()), 64'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
